// File: rtl/rope_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rope_frame_scheduler_pkg
// Brief   : Shared FSM encoding and coordinate-packing helpers for the rope
//           scheduler and the graphics block.
// Revision: 1.0
// ============================================================================
package rope_frame_scheduler_pkg;

    localparam int c_COORD_W    = 10;
    localparam int c_STEP_CNT_W = 8;
    localparam int c_STATE_W    = 3;

    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_INIT = 3'd0;
    localparam state_t c_ST_IDLE = 3'd1;
    localparam state_t c_ST_STEP = 3'd2;
    localparam state_t c_ST_WAIT = 3'd3;
    localparam state_t c_ST_COPY = 3'd4;
    localparam state_t c_ST_DONE = 3'd5;

    // Node k occupies [node_lsb(k, W) +: W] in a packed coordinate bus.
    function automatic int node_lsb(input int k, input int coord_w);
        return k * coord_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rope_frame_scheduler_vsync_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : vsync_edge_sync
// Brief   : Two-flop vsync synchronizer with a falling-edge frame_start pulse.
// Revision: 1.0
// ============================================================================
module vsync_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic frame_start
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    // Flops reset to the vsync idle level so reset release never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_meta   <= vsync;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign frame_start = r_sync_d & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/rope_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : rope_frame_scheduler
// Brief   : Per-frame step/ack sequencer for the rope datapath with a shadow
//           coordinate snapshot for the renderer.
// Revision: 1.0
// ============================================================================
module rope_frame_scheduler
    import rope_frame_scheduler_pkg::*;
#(
    parameter int N_NODES         = 20,
    parameter int COORD_W         = c_COORD_W,
    parameter int STEPS_PER_FRAME = 7,
    parameter int STEP_TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vsync,
    output logic                       rope_reset,
    output logic                       step_req,
    input  logic                       step_ack,
    input  logic [N_NODES*COORD_W-1:0] nodes_x_in,
    input  logic [N_NODES*COORD_W-1:0] nodes_y_in,
    output logic [N_NODES*COORD_W-1:0] nodes_x_out,
    output logic [N_NODES*COORD_W-1:0] nodes_y_out,
    output logic                       frame_ready,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int c_K_W  = $clog2(N_NODES);
    localparam int c_TO_W = $clog2(STEP_TIMEOUT + 1);

    localparam logic [c_STEP_CNT_W-1:0] c_LAST_STEP = c_STEP_CNT_W'(STEPS_PER_FRAME - 1);
    localparam logic [c_K_W-1:0]        c_LAST_NODE = c_K_W'(N_NODES - 1);
    localparam logic [c_TO_W-1:0]       c_TO_LAST   = c_TO_W'(STEP_TIMEOUT - 1);

    state_t                     r_state;
    state_t                     w_next_state;
    logic [c_STEP_CNT_W-1:0]    r_step_cnt;
    logic [c_K_W-1:0]           r_k;
    logic [c_TO_W-1:0]          r_to_cnt;
    logic [N_NODES*COORD_W-1:0] r_x_out;
    logic [N_NODES*COORD_W-1:0] r_y_out;
    logic                       r_overrun;
    logic                       r_timeout_err;

    logic w_frame_start;
    logic w_accepting;
    logic w_in_wait;
    logic w_to_hit;
    logic w_leave_wait;
    logic w_last_step;
    logic w_in_copy;
    logic w_last_node;

    vsync_edge_sync u_vsync_sync (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .frame_start (w_frame_start)
    );

    assign w_accepting  = (r_state == c_ST_INIT) || (r_state == c_ST_IDLE);
    assign w_in_wait    = (r_state == c_ST_WAIT);
    assign w_in_copy    = (r_state == c_ST_COPY);
    // The WAIT cycle holding count STEP_TIMEOUT-1 is the last one we spend there.
    assign w_to_hit     = (r_to_cnt == c_TO_LAST);
    assign w_leave_wait = w_in_wait && (step_ack || w_to_hit);
    assign w_last_step  = (r_step_cnt == c_LAST_STEP);
    assign w_last_node  = (r_k == c_LAST_NODE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_INIT: if (w_frame_start) w_next_state = c_ST_STEP;
            c_ST_IDLE: if (w_frame_start) w_next_state = c_ST_STEP;
            c_ST_STEP: w_next_state = c_ST_WAIT;
            c_ST_WAIT: begin
                if (w_leave_wait) begin
                    w_next_state = w_last_step ? c_ST_COPY : c_ST_STEP;
                end
            end
            c_ST_COPY: if (w_last_node) w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_INIT;
        endcase
    end

    always_comb begin
        rope_reset  = (r_state == c_ST_INIT);
        step_req    = (r_state == c_ST_STEP);
        frame_ready = (r_state == c_ST_DONE);
        busy        = !w_accepting;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_cnt    <= '0;
            r_to_cnt      <= '0;
            r_k           <= '0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accepting && w_frame_start) begin
                r_step_cnt <= '0;
            end else if (w_leave_wait) begin
                r_step_cnt <= r_step_cnt + c_STEP_CNT_W'(1);
            end

            if (r_state == c_ST_STEP) begin
                r_to_cnt <= '0;
            end else if (w_in_wait && !w_leave_wait) begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end

            if (w_leave_wait && w_last_step) begin
                r_k <= '0;
            end else if (w_in_copy && !w_last_node) begin
                r_k <= r_k + c_K_W'(1);
            end

            if (w_frame_start && !w_accepting) begin
                r_overrun <= 1'b1;
            end

            // A late ack landing on the final WAIT cycle still counts as an ack.
            if (w_in_wait && w_to_hit && !step_ack) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_NODES; i++) begin : g_node
        localparam int c_LSB = node_lsb(i, COORD_W);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_x_out[c_LSB +: COORD_W] <= '0;
                r_y_out[c_LSB +: COORD_W] <= '0;
            end else if (w_in_copy && (r_k == c_K_W'(i))) begin
                r_x_out[c_LSB +: COORD_W] <= nodes_x_in[c_LSB +: COORD_W];
                r_y_out[c_LSB +: COORD_W] <= nodes_y_in[c_LSB +: COORD_W];
            end
        end
    end

    assign nodes_x_out = r_x_out;
    assign nodes_y_out = r_y_out;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_rope_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_rope_frame_scheduler
// Brief   : Scoreboard bench for rope_frame_scheduler with a randomized rope model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_rope_frame_scheduler;

    localparam int N   = 20;
    localparam int W   = 10;
    localparam int S   = 7;
    localparam int TO  = 255;
    localparam int BUS = N * W;

    logic           clk = 1'b0;
    logic           reset;
    logic           vsync;
    logic           step_ack;
    logic           rope_reset;
    logic           step_req;
    logic           frame_ready;
    logic           busy;
    logic           overrun;
    logic           timeout_err;
    logic [BUS-1:0] nodes_x_in;
    logic [BUS-1:0] nodes_y_in;
    logic [BUS-1:0] nodes_x_out;
    logic [BUS-1:0] nodes_y_out;

    always #5 clk = ~clk;

    rope_frame_scheduler #(
        .N_NODES         (N),
        .COORD_W         (W),
        .STEPS_PER_FRAME (S),
        .STEP_TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .rope_reset  (rope_reset),
        .step_req    (step_req),
        .step_ack    (step_ack),
        .nodes_x_in  (nodes_x_in),
        .nodes_y_in  (nodes_y_in),
        .nodes_x_out (nodes_x_out),
        .nodes_y_out (nodes_y_out),
        .frame_ready (frame_ready),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    typedef struct {
        int unsigned    cyc;
        logic [BUS-1:0] x;
        logic [BUS-1:0] y;
        bit             terr;
        bit             ovr;
    } exp_t;

    exp_t           sb[$];
    int             vectors     = 0;
    int             miscompares = 0;
    int unsigned    cyc         = 0;
    int             step_seen;
    int             delays[S];
    int             step_idx    = 0;
    int             ack_cnt;
    bit             stray_ack   = 1'b0;
    bit             exp_terr    = 1'b0;
    bit             exp_ovr     = 1'b0;
    logic [BUS-1:0] last_x      = '0;
    logic [BUS-1:0] last_y      = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Rope model: acks delays[i] cycles after the i-th request; a zero delay never acks.
    initial begin
        step_ack = 1'b0;
        ack_cnt  = 0;
        forever begin
            @(negedge clk);
            step_ack  = stray_ack;
            stray_ack = 1'b0;
            if (reset) begin
                ack_cnt = 0;
            end else begin
                if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) step_ack = 1'b1;
                end
                if (step_req) begin
                    ack_cnt = (step_idx < S) ? delays[step_idx] : 1;
                    step_idx++;
                end
            end
        end
    end

    // Monitor: every frame_ready pops one expected frame from the scoreboard.
    initial begin
        exp_t e;
        step_seen = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                step_seen = 0;
            end else begin
                if (step_req) step_seen++;
                if (frame_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_frame_ready", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("frame_ready_cycle", cyc, e.cyc);
                        check("shadow_x", nodes_x_out, e.x);
                        check("shadow_y", nodes_y_out, e.y);
                        check("step_count", step_seen, S);
                        check("timeout_err", timeout_err, e.terr);
                        check("overrun", overrun, e.ovr);
                    end
                    step_seen = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x_out"}, nodes_x_out, '0);
        check({tag, "_y_out"}, nodes_y_out, '0);
        check({tag, "_rope_reset"}, rope_reset, 1);
        check({tag, "_step_req"}, step_req, 0);
        check({tag, "_frame_ready"}, frame_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // ack_mode: 0 random 1..3 with occasional timeout, 1 never ack, 2 always next cycle.
    task automatic plan_frame(input bit use_pattern, input int ack_mode, output int lat);
        lat = 2 + N + 1;
        for (int i = 0; i < S; i++) begin
            case (ack_mode)
                0:       delays[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
                1:       delays[i] = 0;
                default: delays[i] = 1;
            endcase
            if (delays[i] == 0) begin
                lat += 1 + TO;
                exp_terr = 1'b1;
            end else begin
                lat += 1 + delays[i];
            end
        end
        for (int k = 0; k < N; k++) begin
            nodes_x_in[k*W +: W] = use_pattern ? W'(k)     : W'($urandom);
            nodes_y_in[k*W +: W] = use_pattern ? W'(2 * k) : W'($urandom);
        end
    endtask

    task automatic run_frame(input bit use_pattern, input int ack_mode, input bit overlap);
        int          lat;
        int          budget;
        int unsigned fall;
        exp_t        e;
        plan_frame(use_pattern, ack_mode, lat);
        if (overlap) exp_ovr = 1'b1;
        @(negedge clk);
        step_idx = 0;
        fall     = cyc;
        e.cyc    = fall + lat;
        e.x      = nodes_x_in;
        e.y      = nodes_y_in;
        e.terr   = exp_terr;
        e.ovr    = exp_ovr;
        sb.push_back(e);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (7) @(negedge clk);
        check("busy_mid_frame", busy, 1);
        check("shadow_hold_x", nodes_x_out, last_x);
        check("shadow_hold_y", nodes_y_out, last_y);
        if (overlap) begin
            vsync = 1'b0;
            repeat (2) @(negedge clk);
            vsync = 1'b1;
        end
        budget = 0;
        while (sb.size() != 0 && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0) begin
            check("frame_timeout", 0, 1);
            sb.delete();
        end
        last_x = e.x;
        last_y = e.y;
        repeat (40) @(negedge clk);
    endtask

    task automatic reset_during_copy();
        int             lat;
        int unsigned    fall;
        logic [BUS-1:0] part_x;
        logic [BUS-1:0] part_y;
        plan_frame(1'b0, 2, lat);
        for (int k = 0; k < N; k++) begin
            part_x[k*W +: W] = (k < 10) ? nodes_x_in[k*W +: W] : last_x[k*W +: W];
            part_y[k*W +: W] = (k < 10) ? nodes_y_in[k*W +: W] : last_y[k*W +: W];
        end
        @(negedge clk);
        step_idx = 0;
        fall     = cyc;
        vsync    = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        while (cyc < fall + 27) @(negedge clk);
        check("partial_copy_x", nodes_x_out, part_x);
        check("partial_copy_y", nodes_y_out, part_y);
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset    = 1'b0;
        exp_terr = 1'b0;
        exp_ovr  = 1'b0;
        last_x   = '0;
        last_y   = '0;
        repeat (50) @(negedge clk);
        check("init_hold_rope_reset", rope_reset, 1);
        check("init_hold_x", nodes_x_out, '0);
    endtask

    initial begin
        reset      = 1'b1;
        vsync      = 1'b1;
        nodes_x_in = '0;
        nodes_y_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("init_rope_reset", rope_reset, 1);

        run_frame(1'b1, 2, 1'b0);
        check("rope_reset_released", rope_reset, 0);

        stray_ack = 1'b1;
        repeat (5) @(negedge clk);
        check("stray_ack_busy", busy, 0);
        check("stray_ack_steps", step_seen, 0);

        run_frame(1'b0, 2, 1'b0);
        for (int i = 0; i < 4; i++) run_frame(1'b0, 0, 1'b0);
        run_frame(1'b0, 1, 1'b0);
        run_frame(1'b0, 2, 1'b1);
        run_frame(1'b0, 0, 1'b1);
        reset_during_copy();
        run_frame(1'b0, 2, 1'b0);
        run_frame(1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
